// File: rtl/fwd_pkg.sv
// fwd_pkg: shared types for the forwarding scoreboard (stage control record,
// forward-source select, POST_DEPTH bounds, liveness helper).
package fwd_pkg;
   localparam int POST_DEPTH_MIN = 1;
   localparam int POST_DEPTH_MAX = 4;

   typedef struct packed {
      logic valid;
      logic wr_en;
      logic is_load;
   } stage_ctl_t;

   typedef enum logic [2:0] {
      SRC_RF,
      SRC_EX,
      SRC_MEM,
      SRC_MEMLD,
      SRC_WB,
      SRC_POST
   } fwd_src_e;

   function automatic logic is_live(stage_ctl_t c);
      return c.valid && c.wr_en;
   endfunction
endpackage

// File: rtl/fwd_port_sel.sv
// fwd_port_sel: per-read-port youngest-first match, load-use hazard flag and data mux.
// FWD_R0_HARDWIRED_EN: address 0 reads as zero and never hazards.
module fwd_port_sel
   import fwd_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int ADDR_W     = 5,
   parameter int POST_DEPTH = 1
) (
   input  logic                         rd_en_i,
   input  logic [ADDR_W-1:0]            rd_addr_i,
   input  logic [DATA_W-1:0]            rd_data_i,
   input  stage_ctl_t                   ex_ctl_i,
   input  logic [ADDR_W-1:0]            ex_addr_i,
   input  logic [DATA_W-1:0]            ex_data_i,
   input  stage_ctl_t                   mem_ctl_i,
   input  logic [ADDR_W-1:0]            mem_addr_i,
   input  logic [DATA_W-1:0]            mem_data_i,
   input  logic                         mem_load_ready_i,
   input  logic [DATA_W-1:0]            mem_load_data_i,
   input  logic                         wb_live_i,
   input  logic [ADDR_W-1:0]            wb_addr_i,
   input  logic [DATA_W-1:0]            wb_data_i,
   input  logic [POST_DEPTH-1:0]        post_live_i,
   input  logic [POST_DEPTH*ADDR_W-1:0] post_addr_i,
   input  logic [POST_DEPTH*DATA_W-1:0] post_data_i,
   output logic [DATA_W-1:0]            data_o,
   output logic                         hazard_o
);
   fwd_src_e    src;
   logic [1:0]  idx;
   logic        hazard;
   logic        r0;
   logic [DATA_W-1:0] mux;

   // Sources are visited oldest to youngest so the youngest match overwrites.
   always_comb begin
      src    = SRC_RF;
      idx    = '0;
      hazard = 1'b0;
      for (int k = POST_DEPTH - 1; k >= 0; k--) begin
         if (post_live_i[k] && post_addr_i[k*ADDR_W +: ADDR_W] == rd_addr_i) begin
            src = SRC_POST;
            idx = k[1:0];
         end
      end
      if (wb_live_i && wb_addr_i == rd_addr_i) src = SRC_WB;
      if (is_live(mem_ctl_i) && mem_addr_i == rd_addr_i) begin
         src    = !mem_ctl_i.is_load ? SRC_MEM : mem_load_ready_i ? SRC_MEMLD : SRC_RF;
         hazard = mem_ctl_i.is_load && !mem_load_ready_i;
      end
      if (is_live(ex_ctl_i) && ex_addr_i == rd_addr_i) begin
         src    = ex_ctl_i.is_load ? SRC_RF : SRC_EX;
         hazard = ex_ctl_i.is_load;
      end
      if (!rd_en_i) begin
         src    = SRC_RF;
         hazard = 1'b0;
      end
   end

   assign mux = src == SRC_EX    ? ex_data_i :
                src == SRC_MEM   ? mem_data_i :
                src == SRC_MEMLD ? mem_load_data_i :
                src == SRC_WB    ? wb_data_i :
                src == SRC_POST  ? post_data_i[idx*DATA_W +: DATA_W] : rd_data_i;

`ifdef FWD_R0_HARDWIRED_EN
   assign r0 = rd_en_i && rd_addr_i == '0;
`else
   assign r0 = 1'b0;
`endif

   assign data_o   = r0 ? '0 : mux;
   assign hazard_o = hazard && !r0;
endmodule

// File: rtl/fwd_scoreboard.sv
// fwd_scoreboard: operand forwarding and load-use hazard unit with its own MEM/WB/POST
// write-back tracking pipeline. FWD_R0_HARDWIRED_EN: r0 reads zero, r0 writes suppressed.
module fwd_scoreboard
   import fwd_pkg::*;
#(
   parameter int NUM_RD_PORTS = 3,
   parameter int DATA_W       = 32,
   parameter int ADDR_W       = 5,
   parameter int POST_DEPTH   = 1
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           id_valid,
   input  logic [NUM_RD_PORTS-1:0]        id_rd_en,
   input  logic [NUM_RD_PORTS*ADDR_W-1:0] id_rd_addr,
   input  logic [NUM_RD_PORTS*DATA_W-1:0] id_rd_data,
   input  logic                           ex_valid,
   input  logic                           ex_wr_en,
   input  logic                           ex_is_load,
   input  logic [ADDR_W-1:0]              ex_wr_addr,
   input  logic [DATA_W-1:0]              ex_result,
   input  logic                           mem_load_ready,
   input  logic [DATA_W-1:0]              mem_load_data,
   output logic [NUM_RD_PORTS*DATA_W-1:0] fwd_data,
   output logic                           stall_id,
   output logic                           mem_wait,
   output logic                           wb_wr_en,
   output logic [ADDR_W-1:0]              wb_wr_addr,
   output logic [DATA_W-1:0]              wb_wr_data
);
   typedef struct packed {
      stage_ctl_t        ctl;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } stage_t;

   if (POST_DEPTH < POST_DEPTH_MIN || POST_DEPTH > POST_DEPTH_MAX) begin : g_bad_depth
      $error("fwd_scoreboard: POST_DEPTH out of range");
   end

   stage_t ex_stage, mem_q, mem_d;
   logic              wb_live_q, wb_live_d;
   logic [ADDR_W-1:0] wb_addr_q, wb_addr_d;
   logic [DATA_W-1:0] wb_data_q, wb_data_d;
   logic [POST_DEPTH-1:0]             post_live_q;
   logic [POST_DEPTH-1:0][ADDR_W-1:0] post_addr_q;
   logic [POST_DEPTH-1:0][DATA_W-1:0] post_data_q;
   logic [NUM_RD_PORTS-1:0]           hazard;

   assign ex_stage = '{ctl: '{valid: ex_valid, wr_en: ex_wr_en, is_load: ex_is_load},
                       addr: ex_wr_addr, data: ex_result};
   assign mem_wait = is_live(mem_q.ctl) && mem_q.ctl.is_load && !mem_load_ready;

   // A waiting load holds MEM and sends a bubble to WB; POST keeps draining.
   always_comb begin
      mem_d     = mem_wait ? mem_q : ex_stage;
      wb_live_d = !mem_wait && is_live(mem_q.ctl);
      wb_addr_d = mem_q.addr;
      wb_data_d = mem_q.ctl.is_load ? mem_load_data : mem_q.data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q       <= '0;
         wb_live_q   <= 1'b0;
         wb_addr_q   <= '0;
         wb_data_q   <= '0;
         post_live_q <= '0;
         post_addr_q <= '0;
         post_data_q <= '0;
      end else begin
         mem_q          <= mem_d;
         wb_live_q      <= wb_live_d;
         wb_addr_q      <= wb_addr_d;
         wb_data_q      <= wb_data_d;
         post_live_q[0] <= wb_live_q;
         post_addr_q[0] <= wb_addr_q;
         post_data_q[0] <= wb_data_q;
         for (int k = 1; k < POST_DEPTH; k++) begin
            post_live_q[k] <= post_live_q[k-1];
            post_addr_q[k] <= post_addr_q[k-1];
            post_data_q[k] <= post_data_q[k-1];
         end
      end
   end

`ifdef FWD_R0_HARDWIRED_EN
   assign wb_wr_en = wb_live_q && wb_addr_q != '0;
`else
   assign wb_wr_en = wb_live_q;
`endif
   assign wb_wr_addr = wb_addr_q;
   assign wb_wr_data = wb_data_q;

   for (genvar i = 0; i < NUM_RD_PORTS; i++) begin : g_port
      fwd_port_sel #(
         .DATA_W     (DATA_W),
         .ADDR_W     (ADDR_W),
         .POST_DEPTH (POST_DEPTH)
      ) u_sel (
         .rd_en_i          (id_rd_en[i]),
         .rd_addr_i        (id_rd_addr[i*ADDR_W +: ADDR_W]),
         .rd_data_i        (id_rd_data[i*DATA_W +: DATA_W]),
         .ex_ctl_i         (ex_stage.ctl),
         .ex_addr_i        (ex_stage.addr),
         .ex_data_i        (ex_stage.data),
         .mem_ctl_i        (mem_q.ctl),
         .mem_addr_i       (mem_q.addr),
         .mem_data_i       (mem_q.data),
         .mem_load_ready_i (mem_load_ready),
         .mem_load_data_i  (mem_load_data),
         .wb_live_i        (wb_live_q),
         .wb_addr_i        (wb_addr_q),
         .wb_data_i        (wb_data_q),
         .post_live_i      (post_live_q),
         .post_addr_i      (post_addr_q),
         .post_data_i      (post_data_q),
         .data_o           (fwd_data[i*DATA_W +: DATA_W]),
         .hazard_o         (hazard[i])
      );
   end

   assign stall_id = id_valid && (|hazard || mem_wait);
endmodule

// File: tb/tb_fwd_scoreboard.sv
// tb_fwd_scoreboard: directed stimulus with literal expectations plus an in-flight-write
// history model checked against the DUT on every falling edge.
module tb_fwd_scoreboard;
   localparam int NP = 3, DW = 32, AW = 5, PD = 1;

   logic clk = 1'b0, rst_n = 1'b1;
   logic id_valid;
   logic [NP-1:0] id_rd_en;
   logic [NP*AW-1:0] id_rd_addr;
   logic [NP*DW-1:0] id_rd_data;
   logic ex_valid, ex_wr_en, ex_is_load;
   logic [AW-1:0] ex_wr_addr;
   logic [DW-1:0] ex_result;
   logic mem_load_ready;
   logic [DW-1:0] mem_load_data;
   logic [NP*DW-1:0] fwd_data;
   logic stall_id, mem_wait, wb_wr_en;
   logic [AW-1:0] wb_wr_addr;
   logic [DW-1:0] wb_wr_data;
   int checks = 0, errors = 0;

   fwd_scoreboard #(.NUM_RD_PORTS(NP), .DATA_W(DW), .ADDR_W(AW), .POST_DEPTH(PD)) dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rd_en(id_rd_en),
      .id_rd_addr(id_rd_addr), .id_rd_data(id_rd_data), .ex_valid(ex_valid),
      .ex_wr_en(ex_wr_en), .ex_is_load(ex_is_load), .ex_wr_addr(ex_wr_addr),
      .ex_result(ex_result), .mem_load_ready(mem_load_ready), .mem_load_data(mem_load_data),
      .fwd_data(fwd_data), .stall_id(stall_id), .mem_wait(mem_wait), .wb_wr_en(wb_wr_en),
      .wb_wr_addr(wb_wr_addr), .wb_wr_data(wb_wr_data)
   );

   always #5 clk = ~clk;

   task automatic chk(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // Model: h[0] is the write in MEM, h[1] the one in WB, h[2..] the retired shadows.
   typedef struct {
      bit            live;
      bit            ld;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } rec_t;
   rec_t h[$];

   function automatic rec_t bub();
      rec_t r;
      r.live = 0; r.ld = 0; r.a = '0; r.d = '0;
      return r;
   endfunction

   function automatic bit r0(logic [AW-1:0] a);
`ifdef FWD_R0_HARDWIRED_EN
      return a == '0;
`else
      return 1'b0;
`endif
   endfunction

   function automatic bit m_wait();
      return h[0].live && h[0].ld && !mem_load_ready;
   endfunction

   function automatic void exp_port(int i, output logic [DW-1:0] d, output bit hz);
      logic [AW-1:0] a;
      a  = id_rd_addr[i*AW +: AW];
      d  = id_rd_data[i*DW +: DW];
      hz = 0;
      if (!id_rd_en[i]) return;
      if (r0(a)) begin d = '0; return; end
      if (ex_valid && ex_wr_en && ex_wr_addr == a) begin
         if (ex_is_load) hz = 1; else d = ex_result;
         return;
      end
      for (int k = 0; k < h.size(); k++)
         if (h[k].live && h[k].a == a) begin
            if (k == 0 && h[0].ld) begin
               if (mem_load_ready) d = mem_load_data; else hz = 1;
            end else d = h[k].d;
            return;
         end
   endfunction

   always @(posedge clk or negedge rst_n) begin
      rec_t m, e;
      if (!rst_n) begin
         h = {};
         repeat (2 + PD) h.push_back(bub());
      end else begin
         if (m_wait()) h.insert(1, bub());
         else begin
            m = h[0];
            if (m.ld) m.d = mem_load_data;
            h[0] = m;
            e.live = ex_valid && ex_wr_en; e.ld = ex_is_load; e.a = ex_wr_addr; e.d = ex_result;
            h.push_front(e);
         end
         void'(h.pop_back());
      end
   end

   always @(negedge clk) begin
      logic [DW-1:0] d;
      bit hz, any;
      any = 0;
      for (int i = 0; i < NP; i++) begin
         exp_port(i, d, hz);
         any |= hz;
         if (!hz) chk($sformatf("model_fwd%0d", i), fwd_data[i*DW +: DW], d);
      end
      chk("model_stall", stall_id, id_valid && (any || m_wait()));
      chk("model_mem_wait", mem_wait, m_wait());
      chk("model_wb_en", wb_wr_en, h[1].live && !r0(h[1].a));
      if (h[1].live) begin
         chk("model_wb_addr", wb_wr_addr, h[1].a);
         chk("model_wb_data", wb_wr_data, h[1].d);
      end
   end

   task automatic idle();
      id_valid = 0; id_rd_en = '0; id_rd_addr = '0; id_rd_data = '0;
      ex_valid = 0; ex_wr_en = 0; ex_is_load = 0; ex_wr_addr = '0; ex_result = '0;
      mem_load_ready = 0; mem_load_data = '0;
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic port(int i, logic [AW-1:0] a, logic [DW-1:0] d);
      id_rd_en[i] = 1'b1;
      id_rd_addr[i*AW +: AW] = a;
      id_rd_data[i*DW +: DW] = d;
   endtask

   task automatic ex(logic [AW-1:0] a, logic [DW-1:0] d, logic ld);
      ex_valid = 1; ex_wr_en = 1; ex_is_load = ld; ex_wr_addr = a; ex_result = d;
   endtask

   function automatic logic [DW-1:0] fw(int i);
      return fwd_data[i*DW +: DW];
   endfunction

   initial begin
      idle();
      #1 rst_n = 0;
      port(0, 5'd1, 32'h1111); port(1, 5'd2, 32'h2222);
      @(negedge clk);
      chk("rst_stall", stall_id, 0);
      chk("rst_mem_wait", mem_wait, 0);
      chk("rst_wb_en", wb_wr_en, 0);
      chk("rst_wb_addr", wb_wr_addr, 0);
      chk("rst_wb_data", wb_wr_data, 0);
      chk("rst_fwd0", fw(0), 32'h1111);
      chk("rst_fwd1", fw(1), 32'h2222);
      cyc();
      rst_n = 1;
      // EX ALU forward, two ports on the same register
      idle(); id_valid = 1; ex(5'd5, 32'h1234, 0);
      port(0, 5'd2, 32'hAAAA); port(1, 5'd5, 32'h5555); port(2, 5'd5, 32'h6666);
      @(negedge clk);
      chk("ex_fwd1", fw(1), 32'h1234);
      chk("ex_fwd2", fw(2), 32'h1234);
      chk("ex_fwd0_rf", fw(0), 32'hAAAA);
      chk("ex_stall", stall_id, 0);
      cyc();
      // load-use with immediate ready
      idle(); id_valid = 1; ex(5'd3, 32'hDEAD, 1); port(0, 5'd3, 32'h3333);
      @(negedge clk);
      chk("lu_stall", stall_id, 1);
      cyc();
      idle(); id_valid = 1; port(0, 5'd3, 32'h3333); mem_load_ready = 1; mem_load_data = 32'hCAFE;
      @(negedge clk);
      chk("lu_fwd", fw(0), 32'hCAFE);
      chk("lu_stall_clear", stall_id, 0);
      chk("wb5_en", wb_wr_en, 1);
      chk("wb5_addr", wb_wr_addr, 5);
      chk("wb5_data", wb_wr_data, 32'h1234);
      cyc();
      idle();
      @(negedge clk);
      chk("wb3_en", wb_wr_en, 1);
      chk("wb3_addr", wb_wr_addr, 3);
      chk("wb3_data", wb_wr_data, 32'hCAFE);
      cyc();
      // load with three-cycle ready delay, EX held during the wait
      idle(); ex(5'd9, 32'h0, 1);
      cyc();
      for (int j = 0; j < 3; j++) begin
         idle(); ex(5'd10, 32'h77, 0); id_valid = 1; port(2, 5'd9, 32'h9999);
         @(negedge clk);
         chk($sformatf("wait%0d_mem_wait", j), mem_wait, 1);
         chk($sformatf("wait%0d_stall", j), stall_id, 1);
         chk($sformatf("wait%0d_wb_en", j), wb_wr_en, 0);
         cyc();
      end
      idle(); ex(5'd10, 32'h77, 0); id_valid = 1; port(2, 5'd9, 32'h9999);
      mem_load_ready = 1; mem_load_data = 32'hBEEF;
      @(negedge clk);
      chk("ready_mem_wait", mem_wait, 0);
      chk("ready_stall", stall_id, 0);
      chk("ready_fwd2", fw(2), 32'hBEEF);
      cyc();
      idle();
      @(negedge clk);
      chk("wb9_en", wb_wr_en, 1);
      chk("wb9_addr", wb_wr_addr, 9);
      chk("wb9_data", wb_wr_data, 32'hBEEF);
      cyc();
      @(negedge clk);
      chk("wb10_addr", wb_wr_addr, 10);
      chk("wb10_data", wb_wr_data, 32'h77);
      cyc();
      // youngest-wins priority on r7
      idle(); ex(5'd7, 32'h3, 0);
      cyc();
      idle(); ex(5'd7, 32'h2, 0);
      cyc();
      idle(); ex(5'd7, 32'h1, 0); id_valid = 1; port(0, 5'd7, 32'h55);
      @(negedge clk);
      chk("pri_ex", fw(0), 32'h1);
      ex_valid = 0;
      #1 chk("pri_mem", fw(0), 32'h2);
      cyc();
      idle(); port(0, 5'd7, 32'h55);
      @(negedge clk);
      chk("pri_wb", fw(0), 32'h2);
      cyc();
      @(negedge clk);
      chk("pri_post", fw(0), 32'h2);
      cyc();
      @(negedge clk);
      chk("pri_rf", fw(0), 32'h55);
      cyc();
      // r0 handling
      idle(); ex(5'd0, 32'hFF, 0); id_valid = 1; port(0, 5'd0, 32'h0BAD);
      @(negedge clk);
`ifdef FWD_R0_HARDWIRED_EN
      chk("r0_fwd", fw(0), 32'h0);
`else
      chk("r0_fwd", fw(0), 32'hFF);
`endif
      cyc();
      idle();
      cyc();
      @(negedge clk);
`ifdef FWD_R0_HARDWIRED_EN
      chk("r0_wb_en", wb_wr_en, 0);
`else
      chk("r0_wb_en", wb_wr_en, 1);
`endif
      cyc();
      // asynchronous reset in the middle of a load wait
      idle(); ex(5'd4, 32'h0, 1);
      cyc();
      idle(); id_valid = 1; port(1, 5'd4, 32'h4444);
      @(negedge clk);
      chk("pre_rst_mem_wait", mem_wait, 1);
      chk("pre_rst_stall", stall_id, 1);
      #2 rst_n = 0;
      #1;
      chk("mid_rst_mem_wait", mem_wait, 0);
      chk("mid_rst_stall", stall_id, 0);
      chk("mid_rst_wb_en", wb_wr_en, 0);
      chk("mid_rst_fwd1", fw(1), 32'h4444);
      cyc();
      cyc();
      rst_n = 1;
      idle(); id_valid = 1; port(1, 5'd4, 32'h4444);
      @(negedge clk);
      chk("post_rst_fwd1", fw(1), 32'h4444);
      chk("post_rst_stall", stall_id, 0);
      cyc();
      idle();
      cyc();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
